// File: rtl/flappy_bird_control_key_pio.sv
// flappy_bird_control_key_pio
//   Avalon-MM input port for the DE2-115 pushbuttons. Each key is passed
//   through a two-flop synchronizer and a per-bit debounce counter. Edges of
//   the debounced level set sticky capture bits. A maskable level interrupt
//   tells the CPU that a key event is pending.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits >= WIDTH ignored)
//   in_port     raw asynchronous key inputs
//   readdata    registered read data, one cycle of latency
//   irq         active-high level interrupt: |(EDGECAP & IRQMASK)
module flappy_bird_control_key_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter int unsigned IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_dly_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  assign wr_en = chipselect && !write_n;

  // Debounce: any sample equal to the accepted level restarts the count, so
  // a new level is only taken after DEBOUNCE_CYCLES consecutive differing
  // samples. The counter is cleared on acceptance and cannot run past CNT_MAX.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_evt = stable_q & ~stable_dly_q;
      1:       edge_evt = ~stable_q & stable_dly_q;
      default: edge_evt = stable_q ^ stable_dly_q;
    endcase
  end

  // A new event on a bit overrides a write-1-clear of that bit in the same
  // cycle, so a press can never be lost to a concurrent acknowledge.
  always_comb begin
    clr_bits = '0;
    mask_d   = mask_q;
    if (wr_en && address == ADDR_EDGECAP) clr_bits = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_IRQMASK) mask_d   = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_bits) | edge_evt;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable_q;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= IDLE_VEC;
      sync2_q      <= IDLE_VEC;
      stable_q     <= IDLE_VEC;
      stable_dly_q <= IDLE_VEC;
      edgecap_q    <= '0;
      mask_q       <= '0;
      readdata_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= in_port;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      edgecap_q    <= edgecap_d;
      mask_q       <= mask_d;
      readdata_q   <= readdata_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: doc/flappy_bird_control_key_pio.md
# flappy_bird_control_key_pio

Memory-mapped input port for the Flappy Bird control system: brings the DE2-115 pushbuttons (active-low) onto the Avalon-MM bus. It is the read-side counterpart of the system's output PIO registers. Each input bit is synchronized and debounced, and edges are captured in sticky bits. A maskable interrupt tells the Nios II when the player presses a key.

## Interface
- WIDTH, 4: number of input bits (1..16).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level (≥2; 1 ms at 50 MHz).
- EDGE_TYPE, 1: edge that sets a capture bit; 0 = rising, 1 = falling (key press), 2 = any.
- IDLE_LEVEL, 1: reset value of the synchronizer and debounced state, per bit (keys released).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous key inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

## Operation
Register map (bits ≥ WIDTH always read 0; writes to them are ignored):
- 0 DATA: read returns the debounced state. Writes are ignored.
- 1 reserved: reads 0. Writes are ignored.
- 2 IRQMASK: read/write, reset 0.
- 3 EDGECAP: read returns the capture bits. Writing 1 to a bit clears it; writing 0 to a bit leaves it unchanged.

Datapath, per bit i:
- sync1/sync2: two-flop synchronizer. Reset value is IDLE_LEVEL.
- Debounce counter cnt[i]: width is clog2(DEBOUNCE_CYCLES).
  - When sync2[i] == stable[i], cnt[i] is set to 0.
  - When sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1, stable[i] takes sync2[i] and cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
  - Any return to the stable level restarts the count. Glitches shorter than DEBOUNCE_CYCLES therefore never propagate.
- stable_d[i]: stable[i] delayed by one cycle. Reset value is IDLE_LEVEL, so reset never produces an edge.
- Edge event:
  - rising = stable & ~stable_d
  - falling = ~stable & stable_d
  - any = stable ^ stable_d
  - The event selected by EDGE_TYPE sets EDGECAP[i] on the next clock.
- Simultaneous set event and write-1-clear on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), decoded combinationally from registers. Reset value is 0.

Bus behaviour:
- A write occurs when chipselect && !write_n.
- readdata is updated every clock from the address mux, independent of chipselect. Reset value is 0.
- No wait states.

## Timing
- Read latency is 1 cycle: readdata is valid on the clock edge after address is presented.
- Write takes effect on the same clock edge. A new IRQMASK or EDGECAP value is visible in irq immediately after that edge.
- Input latency: suppose in_port changes and holds before clock edge E.
  - sync2 updates at E+1.
  - stable updates at E+1+DEBOUNCE_CYCLES.
  - EDGECAP (and irq, if the bit is masked in) sets at E+2+DEBOUNCE_CYCLES.
  - The DATA read reflects the new level from E+2+DEBOUNCE_CYCLES.
- Reset mid-operation:
  - All counters are cleared, and stable/stable_d/sync are forced to IDLE_LEVEL.
  - EDGECAP, IRQMASK, readdata and irq go to 0 asynchronously.
  - After release, a held key is accepted as a fresh edge after the full latency.
- Counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around path.

## Test plan
Bench parameters: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless stated.
- Reset: assert reset_n=0 with in_port=0xF -> readdata=0, irq=0. Read addr 0 -> 0xF. Read addr 2 and 3 -> 0.
- Clean press: drive in_port 0xF→0xE before edge E and hold -> DATA reads 0xF until E+6, then 0xE. EDGECAP=0x1 from E+6. irq=0. Write IRQMASK=0x1 -> irq=1 after that edge.
- Bounce rejection: toggle in_port[1] every 2 cycles for 20 cycles, then hold at 1 -> DATA stays 0xF, EDGECAP=0, irq=0 throughout. A 3-cycle low pulse is also rejected.
- Clear:
  - With EDGECAP=0x1 and IRQMASK=0x1, write 0x1 to addr 3 -> EDGECAP=0 and irq=0 after that edge.
  - Write 0x0 to addr 3 -> no change.
  - Force a new falling edge on bit 0 in the same cycle as a write-1-clear -> EDGECAP bit 0 remains 1.
- Reset mid-debounce: hold in_port[2]=0, then pulse reset_n low 2 cycles after the sync2 change -> no capture before release. After release, EDGECAP=0x4 at release+6.
- EDGE_TYPE=2, with a press then a release (each held ≥4 cycles) -> EDGECAP bit sets on both. Write addr 0/1 -> no register change. Reads of addr 1 return 0.
